// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and lock-state encoding for the VGA sync decoder.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vga_lock_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Two-flop sampler of one sync/blank input with rise/fall pulses between the two stages.
module vga_edge_det (
  input  logic vga_clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign level = s1;
  assign rise  = s1 & ~s2;
  assign fall  = ~s1 & s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: pixel coordinates, line/frame measurement and lock FSM.
// Define VGA_SYNC_ERRCNT_EN to build the saturating violation counter on err_count.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned HW          = 10,
  parameter int unsigned VW          = 10
) (
  input  logic          vga_clock,
  input  logic          reset_n,
  input  logic          hsync_n,
  input  logic          vsync_n,
  input  logic          blank_n,
  output logic          pixel_valid,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          frame_start,
  output logic          locked,
  output logic          sync_err,
  output logic [HW-1:0] h_meas,
  output logic [VW-1:0] v_meas,
  output logic [15:0]   err_count
);

  localparam int unsigned TO_LIM = 2 * H_TOTAL;
  // Line counter is widened so the 2*H_TOTAL timeout stays reachable when HW is narrow.
  localparam int unsigned HCW = max_u(HW, $clog2(TO_LIM + 1));
  localparam logic [HCW:0]  H_TOTAL_L = (HCW+1)'(H_TOTAL);
  localparam logic [HCW:0]  TO_LIM_L  = (HCW+1)'(TO_LIM);
  localparam logic [VW:0]   V_TOTAL_L = (VW+1)'(V_TOTAL);
  localparam logic [3:0]    LOCK_L    = 4'(LOCK_FRAMES);

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic bl_lvl, bl_rise, bl_fall;
  logic unused_edges;

  vga_edge_det u_hs (.vga_clock(vga_clock), .reset_n(reset_n), .din(hsync_n),
                     .level(hs_lvl), .rise(hs_rise), .fall(hs_fall));
  vga_edge_det u_vs (.vga_clock(vga_clock), .reset_n(reset_n), .din(vsync_n),
                     .level(vs_lvl), .rise(vs_rise), .fall(vs_fall));
  vga_edge_det u_bl (.vga_clock(vga_clock), .reset_n(reset_n), .din(blank_n),
                     .level(bl_lvl), .rise(bl_rise), .fall(bl_fall));

  assign unused_edges = ^{hs_lvl, hs_rise, vs_lvl, vs_rise};

  logic [HCW-1:0]  h_ctr;
  logic            h_seen;
  logic [VW-1:0]   v_ctr;
  logic            line_bad;
  logic [3:0]      good_cnt, good_nxt;
  vga_lock_state_t state, state_nxt;

  logic [HCW:0]  h_len;
  logic [VW-1:0] v_inc, v_len;
  logic          line_viol, timeout, frame_viol, any_viol;

  always_comb begin
    h_len      = {1'b0, h_ctr} + (HCW+1)'(1);
    line_viol  = hs_fall && h_seen && (h_len != H_TOTAL_L);
    timeout    = !hs_fall && (h_len == TO_LIM_L);
    v_inc      = (&v_ctr) ? v_ctr : v_ctr + VW'(1);
    v_len      = hs_fall ? v_inc : v_ctr;
    // The frame that first hands SEARCH a vsync is partial, so frames are judged only afterwards.
    frame_viol = vs_fall && (state != SEARCH) &&
                 (({1'b0, v_len} != V_TOTAL_L) || line_bad || line_viol || timeout);
    any_viol   = line_viol | timeout | frame_viol;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    unique case (state)
      SEARCH: begin
        good_nxt = '0;
        if (vs_fall && !any_viol) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (any_viol) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end else if (vs_fall) begin
          if (good_cnt + 4'd1 >= LOCK_L) state_nxt = LOCKED;
          good_nxt = good_cnt + 4'd1;
        end
      end
      LOCKED: begin
        if (any_viol) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_ctr       <= '0;
      h_seen      <= 1'b0;
      v_ctr       <= '0;
      line_bad    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
    end else begin
      pixel_valid <= bl_lvl;
      frame_start <= vs_fall;
      sync_err    <= any_viol;
      locked      <= (state_nxt == LOCKED);
      line_bad    <= vs_fall ? 1'b0 : (line_bad | line_viol | timeout);

      if (hs_fall) begin
        h_ctr  <= '0;
        h_seen <= 1'b1;
        h_meas <= (|h_len[HCW:HW]) ? '1 : h_len[HW-1:0];
      end else begin
        if (!(&h_ctr)) h_ctr <= h_ctr + HCW'(1);
        if (timeout) h_seen <= 1'b0;
      end

      if (vs_fall) begin
        v_ctr  <= '0;
        v_meas <= v_len;
      end else if (hs_fall) begin
        v_ctr <= v_inc;
      end

      if (bl_rise) pixel_x <= '0;
      else if (bl_lvl) pixel_x <= pixel_x + HW'(1);

      if (vs_fall) pixel_y <= '0;
      else if (bl_fall) pixel_y <= pixel_y + VW'(1);
    end
  end

`ifdef VGA_SYNC_ERRCNT_EN
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) err_count <= '0;
    else if (any_viol && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 40x20 raster (24x12 active).
module tb_vga_sync_decoder;

  localparam int HT = 40, HA = 24, HSS = 28, HSE = 34, STALL_H = 36;
  localparam int VT = 20, VA = 12, VSS = 14, VSE = 16, LF = 2;
`ifdef VGA_SYNC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic vga_clock = 1'b0, reset_n = 1'b0;
  logic hsync_n = 1'b1, vsync_n = 1'b1, blank_n = 1'b0;
  logic pixel_valid, frame_start, locked, sync_err;
  logic [9:0] pixel_x, h_meas, pixel_y, v_meas;
  logic [15:0] err_count;

  vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF), .HW(10), .VW(10)) dut (
    .vga_clock(vga_clock), .reset_n(reset_n), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .blank_n(blank_n), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err), .h_meas(h_meas),
    .v_meas(v_meas), .err_count(err_count));

  always #5 vga_clock = ~vga_clock;

  int cyc = 0;
  always @(posedge vga_clock) cyc <= cyc + 1;

  typedef struct {int cyc; bit lk; int vm; int hm; int pc;} ev_t;
  typedef struct {int cyc; int x; int y;} px_t;
  ev_t fs_q[$];
  ev_t err_q[$];
  px_t px_q[$];

  int tests = 0, fails = 0;
  int acq = 0, lines = 0, pix = 0, exp_err = 0;
  bit dc = 1'b0, pend = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pixel_valid"}, pixel_valid, 0);
    chk({tag, "_pixel_x"}, pixel_x, 0);
    chk({tag, "_pixel_y"}, pixel_y, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_h_meas"}, h_meas, 0);
    chk({tag, "_v_meas"}, v_meas, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // Expected responses derived from what the raster generator is about to drive.
  task automatic book(input int h, input int v, input bit stall, input bit supp, input bit supp_prev);
    if (v == VSS && h == 0) begin
      acq++;
      fs_q.push_back(ev_t'{cyc + 2, acq >= LF + 1, dc ? -1 : lines, HT, dc ? -1 : pix});
      lines = 0;
      pix   = 0;
      dc    = 1'b0;
    end
    if (h == HSS) begin
      if (!supp) begin
        lines++;
        if (pend) begin
          err_q.push_back(ev_t'{cyc + 2, 1'b0, -1, HT + 1, -1});
          pend = 1'b0;
          acq  = 0;
          exp_err++;
        end
      end else if (supp_prev) begin
        err_q.push_back(ev_t'{cyc + 2, 1'b0, -1, HT, -1});
        acq = 0;
        exp_err++;
      end
    end
    if (blank_n) begin
      pix++;
      if (!dc) px_q.push_back(px_t'{cyc + 2, h, v});
    end
    if (stall && h == STALL_H) pend = 1'b1;
  endtask

  task automatic drive_frame(input logic [31:0] stall_m, input logic [31:0] supp_m, input int rst_line);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        int reps;
        reps = (stall_m[v] && h == STALL_H) ? 2 : 1;
        for (int r = 0; r < reps; r++) begin
          @(posedge vga_clock);
          #1;
          hsync_n = !(h >= HSS && h < HSE && !supp_m[v]);
          vsync_n = !(v >= VSS && v < VSE);
          blank_n = (h < HA) && (v < VA);
          if (h == 7 && v == rst_line) reset_n = 1'b1;
          if (r == 0) book(h, v, stall_m[v], supp_m[v], (v > 0) ? supp_m[v-1] : 1'b0);
          if (h == 4 && v == rst_line) begin
            #2;
            reset_n = 1'b0;
            px_q.delete();
            dc = 1'b1;
            acq = 0;
            exp_err = 0;
            pend = 1'b0;
            #1;
            check_zero("midreset");
          end
        end
      end
    end
  endtask

  initial begin
    int mpix;
    ev_t e;
    px_t p;
    mpix = 0;
    forever begin
      @(posedge vga_clock);
      #2;
      if (!reset_n) begin
        mpix = 0;
      end else begin
        while (px_q.size() > 0 && px_q[0].cyc < cyc) begin
          chk("pixel_valid_cycle", cyc, px_q[0].cyc);
          void'(px_q.pop_front());
        end
        while (fs_q.size() > 0 && fs_q[0].cyc < cyc) begin
          chk("frame_start_cycle", cyc, fs_q[0].cyc);
          void'(fs_q.pop_front());
        end
        while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
          chk("sync_err_cycle", cyc, err_q[0].cyc);
          void'(err_q.pop_front());
        end
        if (pixel_valid) begin
          mpix++;
          if (px_q.size() > 0 && px_q[0].cyc == cyc) begin
            p = px_q.pop_front();
            chk("pixel_x", pixel_x, p.x);
            chk("pixel_y", pixel_y, p.y);
          end
        end
        if (frame_start) begin
          if (fs_q.size() == 0) chk("frame_start_unexpected", 1, 0);
          else begin
            e = fs_q.pop_front();
            chk("frame_start_cycle", cyc, e.cyc);
            chk("locked_at_vsync", locked, e.lk);
            chk("h_meas_at_vsync", h_meas, e.hm);
            if (e.vm >= 0) chk("v_meas", v_meas, e.vm);
            if (e.pc >= 0) chk("pixels_per_frame", mpix, e.pc);
          end
          mpix = 0;
        end
        if (sync_err) begin
          if (err_q.size() == 0) chk("sync_err_unexpected", 1, 0);
          else begin
            e = err_q.pop_front();
            chk("sync_err_cycle", cyc, e.cyc);
            chk("locked_at_err", locked, 0);
            chk("h_meas_at_err", h_meas, e.hm);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge vga_clock);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    repeat (5) drive_frame('0, '0, -1);

    drive_frame(32'h1 << 5, '0, -1);
    repeat (3) drive_frame('0, '0, -1);
    chk("err_count_after_stretch", err_count, ERRCNT ? exp_err : 0);

    drive_frame('0, (32'h1 << 5) | (32'h1 << 6), -1);
    repeat (3) drive_frame('0, '0, -1);

    drive_frame((32'h1 << 3) | (32'h1 << 5) | (32'h1 << 7), '0, -1);
    repeat (3) drive_frame('0, '0, -1);
    chk("err_count_after_bad_lines", err_count, ERRCNT ? exp_err : 0);

    drive_frame('0, '0, 8);
    repeat (4) drive_frame('0, '0, -1);
    chk("err_count_after_reset", err_count, 0);
    chk("locked_final", locked, 1);

    repeat (3) @(posedge vga_clock);
    #3;
    chk("frame_events_left", fs_q.size(), 0);
    chk("err_events_left", err_q.size(), 0);
    chk("pixel_events_left", px_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
